// File: rtl/seg7_scan_display.sv
// Binary-to-BCD (double-dabble) converter with a multiplexed common-anode 7-segment scanner.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_display #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Decimal digits of 2^w-1 equal floor(w*log10(2))+1 since 2^w is never a power of ten.
    function automatic int unsigned req_digits(input int unsigned w);
        logic [63:0] t;
        t = (64'(w) * 64'd301029996) / 64'd1000000000;
        return 32'(t) + 32'd1;
    endfunction

    if (NUM_DIGITS < req_digits(DATA_WIDTH)) begin : g_digits_check
        $error("NUM_DIGITS too small to hold 2^DATA_WIDTH-1");
    end
    if (REFRESH_DIV < 2) begin : g_div_check
        $error("REFRESH_DIV must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    state_e                         state_q, state_d;
    logic [DATA_WIDTH-1:0]          src_q, src_d;
    logic [NUM_DIGITS-1:0][3:0]     bcd_q, bcd_d, bcd_adj;
    logic [BitW-1:0]                bits_q, bits_d;
    logic [NUM_DIGITS-1:0][3:0]     display_q, display_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic [NUM_DIGITS-1:0]          blank;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        bcd_d     = bcd_q;
        bits_d    = bits_q;
        display_d = display_q;
        bcd_adj   = bcd_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    src_d   = value;
                    bcd_d   = '0;
                    bits_d  = BitW'(DATA_WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
                end
                {bcd_d, src_d} = {bcd_adj, src_q} << 1;
                bits_d         = bits_q - BitW'(1);
                if (bits_q == BitW'(1)) state_d = StCommit;
            end
            StCommit: begin
                display_d = bcd_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank every digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (display_q[i] != 4'd0) seen = 1'b1;
            blank[i] = ~seen;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
        if (blank[idx_q]) begin
            an_d  = '1;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = decode(display_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            src_q     <= '0;
            bcd_q     <= '0;
            bits_q    <= '0;
            display_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            bcd_q     <= bcd_d;
            bits_q    <= bits_d;
            display_q <= display_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4; expectations follow the
// SEG7_LEADING_ZERO_BLANK_EN setting of the build.
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] value = 8'd0;
    logic       busy;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;
    int m_cnt = 0;
    int m_idx = 0;
    int m_slot = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DATA_WIDTH (8),
        .NUM_DIGITS (8),
        .REFRESH_DIV(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .value(value),
        .busy (busy),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] dec(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic bit blanked(input int val, input int slot);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        return (slot > 0) && (val < pow10(slot));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int slot);
        if (blanked(val, slot)) return 7'h7F;
        return dec((val / pow10(slot)) % 10);
    endfunction

    function automatic logic [7:0] exp_an(input int val, input int slot);
        if (blanked(val, slot)) return 8'hFF;
        return ~(8'h01 << slot);
    endfunction

    // Advance one clock; m_slot is the digit whose an/seg become visible after this edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_cnt = 0;
            m_idx = 0;
        end else begin
            m_slot = m_idx;
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0 || dp !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold: an=%h seg=%h busy=%b dp=%b want FF 7F 0 1",
                         an, seg, busy, dp);
            end
        end
        reset = 1'b0;
        tick();
        total++;
        if (an !== 8'hFE || seg !== 7'h40 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: an=%h seg=%h busy=%b want FE 40 0", an, seg, busy);
        end
    endtask

    task automatic test_scan();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            total++;
            if (an !== exp_an(0, (i / 4) % 8) || seg !== exp_seg(0, (i / 4) % 8)) begin
                bad++;
                $display("FAIL scan_order[%0d]: an=%h seg=%h want %h %h", i, an, seg,
                         exp_an(0, (i / 4) % 8), exp_seg(0, (i / 4) % 8));
            end
        end
    endtask

    task automatic test_convert();
        int n = 0;
        load  = 1'b1;
        value = 8'd255;
        tick();
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b1) break;
            n++;
            // Pulse load during the COMMIT cycle; it must be dropped.
            if (n == 9) begin
                load  = 1'b1;
                value = 8'd3;
            end
            tick();
            load = 1'b0;
        end
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL busy_len_255: busy cycles=%0d want 9", n);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL commit_load_dropped: busy=%b want 0", busy);
            end
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (an !== exp_an(255, m_slot) || seg !== exp_seg(255, m_slot)) begin
                bad++;
                $display("FAIL show_255 slot %0d: an=%h seg=%h want %h %h", m_slot, an, seg,
                         exp_an(255, m_slot), exp_seg(255, m_slot));
            end
        end
    endtask

    task automatic test_dropped_load();
        int n = 0;
        load  = 1'b1;
        value = 8'd200;
        tick();
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b1) break;
            n++;
            if (n == 3) begin
                load  = 1'b1;
                value = 8'd17;
            end
            tick();
            load = 1'b0;
        end
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL busy_len_200: busy cycles=%0d want 9", n);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_load_dropped: busy=%b want 0", busy);
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (an !== exp_an(200, m_slot) || seg !== exp_seg(200, m_slot)) begin
                bad++;
                $display("FAIL show_200 slot %0d: an=%h seg=%h want %h %h", m_slot, an, seg,
                         exp_an(200, m_slot), exp_seg(200, m_slot));
            end
        end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        load  = 1'b1;
        value = 8'd99;
        tick();
        load = 1'b0;
        for (int i = 0; i < 30 && busy === 1'b1; i++) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_timeout_99: busy=%b want 0", busy);
        end
        for (int i = 0; i < 33; i++) begin
            tick();
            total++;
            if (an !== exp_an(99, m_slot) || seg !== exp_seg(99, m_slot)) begin
                bad++;
                $display("FAIL show_99 slot %0d: an=%h seg=%h want %h %h", m_slot, an, seg,
                         exp_an(99, m_slot), exp_seg(99, m_slot));
            end
        end
        load  = 1'b1;
        value = 8'd42;
        tick();
        load = 1'b0;
        n = 1;
        while (n < 4) begin
            tick();
            n++;
            total++;
            if (busy !== 1'b1 || an !== exp_an(99, m_slot) || seg !== exp_seg(99, m_slot)) begin
                bad++;
                $display("FAIL hold_99_busy: busy=%b an=%h seg=%h want 1 %h %h", busy, an, seg,
                         exp_an(99, m_slot), exp_seg(99, m_slot));
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || an !== 8'hFF || seg !== 7'h7F) begin
            bad++;
            $display("FAIL abort_reset: busy=%b an=%h seg=%h want 0 FF 7F", busy, an, seg);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (busy !== 1'b0 || an !== exp_an(0, m_slot) || seg !== exp_seg(0, m_slot)) begin
                bad++;
                $display("FAIL show_0_after_abort slot %0d: busy=%b an=%h seg=%h want 0 %h %h",
                         m_slot, busy, an, seg, exp_an(0, m_slot), exp_seg(0, m_slot));
            end
        end
    endtask

    task automatic test_small_values();
        int vals[2] = '{7, 0};
        foreach (vals[k]) begin
            load  = 1'b1;
            value = 8'(vals[k]);
            tick();
            load = 1'b0;
            for (int i = 0; i < 30 && busy === 1'b1; i++) tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_timeout_%0d: busy=%b want 0", vals[k], busy);
            end
            tick();
            for (int i = 0; i < 32; i++) begin
                tick();
                total++;
                if (an !== exp_an(vals[k], m_slot) || seg !== exp_seg(vals[k], m_slot)) begin
                    bad++;
                    $display("FAIL show_%0d slot %0d: an=%h seg=%h want %h %h", vals[k], m_slot,
                             an, seg, exp_an(vals[k], m_slot), exp_seg(vals[k], m_slot));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_dropped_load();
        test_reset_abort();
        test_small_values();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised, clocked successor to the combinational value-to-7-segment path.
- Accepts an unsigned binary value of DATA_WIDTH bits and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the resulting digits across NUM_DIGITS common-anode displays using active-low anodes and segments.
- Sits between datapath logic and the board display pins.

Parameters:
- DATA_WIDTH, 8: width of the binary input value.
- NUM_DIGITS, 8: number of digits and anodes driven. Elaboration requires 10^NUM_DIGITS > 2^DATA_WIDTH-1; simulation raises $error otherwise.
- REFRESH_DIV, 100000: clock cycles each digit is held active (1 kHz per digit at 100 MHz). Minimum 2.

Ports:
- clk, input, 1: single system clock; all state is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: one-cycle request to convert value. Ignored while busy=1.
- value, input, DATA_WIDTH: unsigned binary value, sampled on the load cycle.
- busy, output, 1: high while a conversion is in progress.
- an, output, NUM_DIGITS: anode enables, active low, registered. Bit i selects digit i; digit 0 is least significant.
- seg, output, 7: segment outputs {g,f,e,d,c,b,a}, active low, registered.
- dp, output, 1: decimal point, active low; tied off (1).

Behaviour:
- Reset: FSM goes to IDLE; busy=0; display register cleared to all-zero BCD; digit index=0; refresh counter=0; an=all ones; seg=7'h7F; dp=1.
- Reset has priority over every other event, including a conversion in progress (abort; display shows 0).
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: on load=1, capture value into the shift source, clear the 4*NUM_DIGITS-bit BCD register, load bit counter=DATA_WIDTH, go to SHIFT. busy rises on the next edge.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, src} left by 1 and decrement the counter. When the counter reaches 1 on this cycle, go to COMMIT.
  - COMMIT: copy the BCD register into the display register atomically in one cycle, then return to IDLE with busy=0.
- Latency: busy is high for exactly DATA_WIDTH+1 cycles. The display register changes on the same edge busy falls.
- load in the COMMIT cycle, or on any cycle while busy, is dropped; it is not queued.
- The displayed digits never show intermediate conversion values.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, the digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - an = ~(1<<index) and seg = decode(display nibble[index]), both registered one cycle after the index changes.
  - The first active an appears one cycle after reset is released.
  - Scanning runs continuously and independently of conversion.
- Decode, active low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibbles 10-15 are unreachable, but decode to dash 3F.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: any digit above the most significant nonzero digit is blanked. For a blanked digit, its an bit stays 1 for its whole scan slot and seg=7F. Digit 0 is always displayed, so value 0 shows a single "0". The blank mask is computed from the display register, so it changes only on COMMIT or reset.
- When undefined: all NUM_DIGITS digits are displayed, including leading zeros.

Test Plan:
- Defaults with REFRESH_DIV=4: assert reset 3 cycles, then release -> an=FF and seg=7F during reset; one cycle after release an=FE and seg=40; busy=0.
- load=1 with value=255 -> busy high for 9 cycles. After busy falls, the digit 0 slot shows seg=12, digit 1 shows 12, digit 2 shows 24, and digits 3-7 show 40 (macro off).
- Scan order with REFRESH_DIV=4 -> an steps FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles, then wraps to FE.
- load 200, then load 17 three cycles later -> second load ignored; display shows 200 (digit 0 = 40, digit 1 = 40, digit 2 = 24).
- load 99, display it; load 42, then assert reset at busy cycle 4 -> busy=0 the next cycle; all digits show 40; the partial conversion is never displayed.
- Macro on, load 7 -> only the digit 0 slot drives an=FE with seg=78. In the other 7 slots an=FF and seg=7F. Load 0 -> digit 0 shows 40.
